// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one fixed-latency fp_add pipeline among N requesters.
// Round-robin issue of one op per cycle; a tag pipe matched to the adder
// latency steers each result into its requester's response register.
// Optional statistics counters are enabled by defining FP_ARB_STATS_EN.
module fp_add_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = 32,
    parameter int unsigned LAT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N-1:0]   req_sub,
    output logic [N-1:0]   rsp_valid,
    input  logic [N-1:0]   rsp_ready,
    output logic [N*W-1:0] rsp_y,
    output logic [W-1:0]   fpa_a,
    output logic [W-1:0]   fpa_b,
    output logic           fpa_sub,
    output logic           fpa_en,
    input  logic [W-1:0]   fpa_y,
    output logic           busy
`ifdef FP_ARB_STATS_EN
    ,
    output logic [31:0]    stat_issue,
    output logic [31:0]    stat_stall
`endif
);

    localparam int unsigned LG_N = $clog2(N);
    localparam logic [LG_N:0] NUM = (LG_N+1)'(N);

    logic [N-1:0]    outst_q, outst_d;
    logic [LG_N-1:0] ptr_q, ptr_d;
    logic [N-1:0]    eligible;
    logic [N-1:0]    grant;
    logic            grant_vld;
    logic            issue;
    logic [LG_N-1:0] grant_idx;
    logic [LG_N:0]   cand;
    logic [W-1:0]    sel_a, sel_b;
    logic            sel_sub;
    logic [N-1:0]    rsp_hs;

    logic [W-1:0]    fpa_a_q, fpa_b_q;
    logic            fpa_sub_q, fpa_en_q;
    logic [LG_N-1:0] iss_tag_q;

    logic [LAT-1:0]  tp_vld_q;
    logic [LG_N-1:0] tp_tag_q [LAT];
    logic            ret_vld;
    logic [LG_N-1:0] ret_tag;

    logic [N-1:0]    rsp_valid_q;
    logic [N*W-1:0]  rsp_y_q;

    // Round-robin search over eligible requesters starting at ptr_q
    always_comb begin
        eligible  = req_valid & ~outst_q;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (LG_N+1)'(k);
            if (cand >= NUM) begin
                cand = cand - NUM;
            end
            if (!grant_vld && eligible[cand[LG_N-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[LG_N-1:0];
            end
        end
    end

    // One-hot grant, operand select, pointer and outstanding next state
    always_comb begin
        issue   = grant_vld && !reset;
        grant   = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        if (issue) begin
            grant[grant_idx] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                sel_a   = req_a[i*W +: W];
                sel_b   = req_b[i*W +: W];
                sel_sub = req_sub[i];
            end
        end
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (grant_idx == LG_N'(N-1)) ? '0 : grant_idx + LG_N'(1);
        end
        rsp_hs  = rsp_valid_q & rsp_ready;
        // No same-cycle bypass: a freed requester only becomes eligible next cycle
        outst_d = (outst_q & ~rsp_hs) | grant;
    end

    // Arbitration state
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            outst_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            outst_q <= outst_d;
        end
    end

    // Issue registers feeding fp_add; operands hold when nothing issues
    always_ff @(posedge clk) begin
        if (reset) begin
            fpa_a_q   <= '0;
            fpa_b_q   <= '0;
            fpa_sub_q <= 1'b0;
            fpa_en_q  <= 1'b0;
            iss_tag_q <= '0;
        end else begin
            fpa_en_q <= issue;
            if (issue) begin
                fpa_a_q   <= sel_a;
                fpa_b_q   <= sel_b;
                fpa_sub_q <= sel_sub;
                iss_tag_q <= grant_idx;
            end
        end
    end

    // Tag pipe: last stage lines up with fpa_y of the same op
    always_ff @(posedge clk) begin
        if (reset) begin
            tp_vld_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                tp_tag_q[k] <= '0;
            end
        end else begin
            tp_vld_q[0] <= fpa_en_q;
            tp_tag_q[0] <= iss_tag_q;
            for (int k = 1; k < LAT; k++) begin
                tp_vld_q[k] <= tp_vld_q[k-1];
                tp_tag_q[k] <= tp_tag_q[k-1];
            end
        end
    end

    assign ret_vld = tp_vld_q[LAT-1];
    assign ret_tag = tp_tag_q[LAT-1];

    // Response registers: capture on retire, release on handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ret_vld && (ret_tag == LG_N'(i))) begin
                    rsp_valid_q[i]      <= 1'b1;
                    rsp_y_q[i*W +: W]   <= fpa_y;
                end else if (rsp_hs[i]) begin
                    rsp_valid_q[i]      <= 1'b0;
                end
            end
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign fpa_a     = fpa_a_q;
    assign fpa_b     = fpa_b_q;
    assign fpa_sub   = fpa_sub_q;
    assign fpa_en    = fpa_en_q;
    assign busy      = |outst_q;

`ifdef FP_ARB_STATS_EN
    logic [31:0] stat_issue_q, stat_stall_q;
    logic        stall;

    assign stall = |(req_valid & ~grant);

    // Saturating issue and stall-cycle counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issue_q <= '0;
            stat_stall_q <= '0;
        end else begin
            if (issue && (stat_issue_q != '1)) begin
                stat_issue_q <= stat_issue_q + 32'd1;
            end
            if (stall && (stat_stall_q != '1)) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_issue = stat_issue_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one fixed-latency fp_add pipeline among N requesters.
- Each requester issues an operand pair through a valid/ready handshake. Winners are chosen round-robin, one issue per cycle.
- Each issue carries a requester tag through a tag pipe aligned with the adder latency, and the result is steered into that requester's response register.
- Sits between the rasterizer setup/interpolation engines and the single fp_add instance; both fp32 and fp64 adders are supported via W.

Parameters:
- N, 4, number of requesters (2..16)
- W, 32, operand width; 32 or 64, must match the fp_add instance
- LAT, 4, fp_add latency in cycles; must equal FP_ADD_LAT
- LG_N, $clog2(N), derived tag width; not overridden

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  N  request valid per requester
- req_ready  out  N  request accepted this cycle (one-hot or zero)
- req_a  in  N*W  operand a, requester i at [i*W +: W]
- req_b  in  N*W  operand b, same packing
- req_sub  in  N  1 = a-b, 0 = a+b
- rsp_valid  out  N  result available per requester
- rsp_ready  in  N  requester consumes result
- rsp_y  out  N*W  result per requester, same packing
- fpa_a  out  W  to fp_add a
- fpa_b  out  W  to fp_add b
- fpa_sub  out  1  to fp_add sub
- fpa_en  out  1  to fp_add en; high for one cycle per issue
- fpa_y  in  W  from fp_add y
- busy  out  1  OR of all outstanding flags

Behaviour:
- Per-requester outstanding flag:
  - Set on issue; cleared on the response handshake (rsp_valid[i] && rsp_ready[i]).
  - At most one op per requester in flight or held, so response registers are never overwritten.
- Eligibility: requester i is eligible when req_valid[i] && !outstanding[i]. There is no same-cycle bypass: a requester whose response handshakes in cycle T may issue again at T+1 at the earliest.
- Arbitration:
  - Combinational round-robin over eligible requesters, starting at pointer ptr.
  - req_ready = one-hot grant, or all zero when none is eligible.
  - On a grant to g, ptr <= (g+1) mod N; otherwise ptr holds.
- Issue, at the cycle-T handshake:
  - fpa_a/fpa_b/fpa_sub are registered from requester g and driven in T+1.
  - fpa_en = 1 in T+1 only; with no issue, fpa_en = 0 and the fpa operand registers hold.
- Tag pipe:
  - LAT stages of {valid, tag[LG_N-1:0]}, stage 0 loaded with {1, g} in T+1.
  - Stage LAT-1 is valid in cycle T+LAT+1, coincident with fpa_y for that op.
  - In that cycle, rsp_y[tag] <= fpa_y and rsp_valid[tag] <= 1.
- Latency: request accept (T) to rsp_valid high is exactly LAT+2 cycles. Throughput is one op per cycle across requesters.
- Response: rsp_valid[i] and rsp_y[i] stay stable until rsp_ready[i]. rsp_ready while !rsp_valid is ignored.
- Simultaneous events: a retire to i and a handshake on a different j in the same cycle are independent. A retire and a handshake on the same i cannot coincide by construction.
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_y = 0, fpa_a/fpa_b = 0, fpa_sub = 0, fpa_en = 0.
  - ptr = 0, all tag-pipe valids = 0, outstanding = 0, busy = 0.
- Reset mid-operation: in-flight tags are discarded. fp_add has no reset, so fpa_y values appearing after reset are ignored because the tag valids are 0.
- Illegal: a requester changing req_a/req_b/req_sub while req_valid is high and not yet accepted. The bench flags it; RTL behaviour is undefined.

Optional Feature:
- Macro: FP_ARB_STATS_EN.
- Defined:
  - Adds output stat_issue (32 bits), counting issued ops, saturating.
  - Adds output stat_stall (32 bits), counting cycles where some req_valid[i] is high but req_ready[i] is not, saturating.
  - Both counters clear on reset.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op: N=4, LAT=4. Requester 1 issues a=0x3f800000, b=0x40000000, sub=0 at T → fpa_en high at T+1 only; rsp_valid[1] high at T+6 with rsp_y[1]=0x40400000; busy low after the rsp_ready handshake.
- Subtract: requester 0 issues a=0x40400000, b=0x3f800000, sub=1 → rsp_y[0]=0x40000000 after 6 cycles.
- Round-robin: all 4 requesters request continuously from reset, each with rsp_ready=1 → grants in order 0,1,2,3 on consecutive cycles, fpa_en high 4 cycles, each response routed to the correct index.
- Backpressure: requester 2 holds rsp_ready=0 for 10 cycles → rsp_valid[2] and rsp_y[2] stable, req_ready[2]=0 with req_valid[2]=1, while other requesters keep issuing; requester 2 re-issues one cycle after its handshake.
- Reset mid-flight: reset asserted 2 cycles after 3 issues → after reset, no rsp_valid for LAT+4 cycles; ptr=0, so the first grant goes to requester 0.
- With FP_ARB_STATS_EN: the round-robin scenario gives stat_issue=4; requesters 1-3 accumulate stall=1+2+3 cycles, so stat_stall=3 (cycles with any stall).
